// File: rtl/imem_arb_if.sv
// Instruction-memory arbiter bus: fetch port, loader port and the shared
// memory-side signals. The arbiter sits on the slave modport; the requesters
// and the memory model sit on the master modport.
interface imem_arb_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          imem_arb_f_req;
  logic [AW-1:0] imem_arb_f_addr;
  logic          imem_arb_f_gnt;
  logic          imem_arb_f_rvalid;

  logic          imem_arb_l_req;
  logic          imem_arb_l_we;
  logic          imem_arb_l_lock;
  logic [AW-1:0] imem_arb_l_addr;
  logic [DW-1:0] imem_arb_l_wdata;
  logic          imem_arb_l_gnt;
  logic          imem_arb_l_rvalid;

  logic [DW-1:0] imem_arb_rdata;

  logic [AW-1:0] imem_arb_mem_addr;
  logic [DW-1:0] imem_arb_mem_wdata;
  logic          imem_arb_mem_rd;
  logic          imem_arb_mem_wr;
  logic [DW-1:0] imem_arb_mem_rdata;

  modport slave (
    input  imem_arb_f_req, imem_arb_f_addr,
    input  imem_arb_l_req, imem_arb_l_we, imem_arb_l_lock,
    input  imem_arb_l_addr, imem_arb_l_wdata,
    input  imem_arb_mem_rdata,
    output imem_arb_f_gnt, imem_arb_f_rvalid,
    output imem_arb_l_gnt, imem_arb_l_rvalid,
    output imem_arb_rdata,
    output imem_arb_mem_addr, imem_arb_mem_wdata,
    output imem_arb_mem_rd, imem_arb_mem_wr
  );

  modport master (
    output imem_arb_f_req, imem_arb_f_addr,
    output imem_arb_l_req, imem_arb_l_we, imem_arb_l_lock,
    output imem_arb_l_addr, imem_arb_l_wdata,
    output imem_arb_mem_rdata,
    input  imem_arb_f_gnt, imem_arb_f_rvalid,
    input  imem_arb_l_gnt, imem_arb_l_rvalid,
    input  imem_arb_rdata,
    input  imem_arb_mem_addr, imem_arb_mem_wdata,
    input  imem_arb_mem_rd, imem_arb_mem_wr
  );
endinterface

// File: rtl/imem_arb.sv
// Two-requester instruction-memory arbiter. Core fetch and program loader
// share one single-cycle memory port. Grants are combinational from the
// current requests; conflicts are resolved round-robin, and the loader can
// take exclusive ownership with l_lock. Read data returns one cycle after
// the read strobe and is flagged to whichever requester issued it.
module imem_arb #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic     imem_arb_clk,
  input  logic     imem_arb_reset_in,
  imem_arb_if.slave bus
);

  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_RUN  = 2'd1,
    ST_LOCK = 2'd2
  } state_t;

  state_t        state_r;
  state_t        state_nxt_s;
  logic          last_l_r;      // 1: loader held the most recent grant
  logic          last_l_nxt_s;
  logic          rr_f_s;
  logic          rr_l_s;
  logic          pick_f_s;
  logic          pick_l_s;
  logic          f_rvalid_r;
  logic          l_rvalid_r;
  logic [AW-1:0] addr_s;
  logic [DW-1:0] wdata_s;

  // Round-robin choice assuming both ports are eligible.
  always_comb begin
    rr_f_s = 1'b0;
    rr_l_s = 1'b0;
    if (bus.imem_arb_f_req && (!bus.imem_arb_l_req || last_l_r)) begin
      rr_f_s = 1'b1;
    end else if (bus.imem_arb_l_req) begin
      rr_l_s = 1'b1;
    end else begin
      rr_f_s = 1'b0;
      rr_l_s = 1'b0;
    end
  end

  // Grant selection: nothing in INIT, loader-only while lock is held,
  // round-robin otherwise (including the cycle the lock is dropped).
  always_comb begin
    pick_f_s = 1'b0;
    pick_l_s = 1'b0;
    case (state_r)
      ST_RUN: begin
        pick_f_s = rr_f_s;
        pick_l_s = rr_l_s;
      end
      ST_LOCK: begin
        if (bus.imem_arb_l_lock) begin
          pick_l_s = bus.imem_arb_l_req;
        end else begin
          pick_f_s = rr_f_s;
          pick_l_s = rr_l_s;
        end
      end
      default: begin
        pick_f_s = 1'b0;
        pick_l_s = 1'b0;
      end
    endcase
  end

  // Next state and round-robin pointer; the pointer only moves on a grant.
  always_comb begin
    state_nxt_s  = state_r;
    last_l_nxt_s = last_l_r;
    case (state_r)
      ST_INIT: state_nxt_s = ST_RUN;
      ST_RUN: begin
        if (pick_l_s && bus.imem_arb_l_lock) begin
          state_nxt_s = ST_LOCK;
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      ST_LOCK: begin
        if (bus.imem_arb_l_lock) begin
          state_nxt_s = ST_LOCK;
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      default: state_nxt_s = ST_INIT;
    endcase
    if (pick_f_s) begin
      last_l_nxt_s = 1'b0;
    end else if (pick_l_s) begin
      last_l_nxt_s = 1'b1;
    end else begin
      last_l_nxt_s = last_l_r;
    end
  end

  // Memory address / write data mux; zero when nobody is granted.
  always_comb begin
    addr_s  = '0;
    wdata_s = '0;
    if (pick_f_s) begin
      addr_s = bus.imem_arb_f_addr;
    end else if (pick_l_s) begin
      addr_s  = bus.imem_arb_l_addr;
      wdata_s = bus.imem_arb_l_wdata;
    end else begin
      addr_s  = '0;
      wdata_s = '0;
    end
  end

  // State, pointer and read-response tracking; reset drops any response.
  always_ff @(posedge imem_arb_clk or negedge imem_arb_reset_in) begin
    if (!imem_arb_reset_in) begin
      state_r    <= ST_INIT;
      last_l_r   <= 1'b1;
      f_rvalid_r <= 1'b0;
      l_rvalid_r <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      last_l_r   <= last_l_nxt_s;
      f_rvalid_r <= pick_f_s;
      l_rvalid_r <= pick_l_s & ~bus.imem_arb_l_we;
    end
  end

  assign bus.imem_arb_f_gnt     = pick_f_s;
  assign bus.imem_arb_l_gnt     = pick_l_s;
  assign bus.imem_arb_mem_rd    = pick_f_s | (pick_l_s & ~bus.imem_arb_l_we);
  assign bus.imem_arb_mem_wr    = pick_l_s & bus.imem_arb_l_we;
  assign bus.imem_arb_mem_addr  = addr_s;
  assign bus.imem_arb_mem_wdata = wdata_s;
  assign bus.imem_arb_f_rvalid  = f_rvalid_r;
  assign bus.imem_arb_l_rvalid  = l_rvalid_r;
  assign bus.imem_arb_rdata     = bus.imem_arb_mem_rdata;

endmodule

// File: tb/tb_imem_arb.sv
// Bench for imem_arb: directed scenarios with literal expectations, then a
// long randomized run. A behavioural model (who owns the memory, whose turn
// a conflict is, which responses are owed next cycle) is compared against
// every output on every falling clock edge.
module tb_imem_arb;
  localparam int AW = 32;
  localparam int DW = 32;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_pass   = 0;
  logic [DW-1:0] rd_val;

  imem_arb_if #(.AW(AW), .DW(DW)) bus();

  imem_arb #(.AW(AW), .DW(DW)) dut (
    .imem_arb_clk      (clk),
    .imem_arb_reset_in (rst_n),
    .bus               (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", nm, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  int            init_left  = 1;    // cycles still to wait after reset
  bit            exclusive  = 1'b0; // loader owns the memory
  bit            fetch_turn = 1'b1; // fetch wins the next conflict
  bit            pend_f     = 1'b0; // response owed to fetch this cycle
  bit            pend_l     = 1'b0; // response owed to loader this cycle
  bit            win_f;
  bit            win_l;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_wdata;

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_gnt",    {bus.imem_arb_f_gnt, bus.imem_arb_l_gnt}, 64'd0);
      chk("rst_strobe", {bus.imem_arb_mem_rd, bus.imem_arb_mem_wr}, 64'd0);
      chk("rst_rvalid", {bus.imem_arb_f_rvalid, bus.imem_arb_l_rvalid}, 64'd0);
      chk("rst_addr",   bus.imem_arb_mem_addr, 64'd0);
      init_left  = 1;
      exclusive  = 1'b0;
      fetch_turn = 1'b1;
      pend_f     = 1'b0;
      pend_l     = 1'b0;
    end else begin
      win_f = 1'b0;
      win_l = 1'b0;
      if (init_left > 0) begin
        win_f = 1'b0;
      end else if (exclusive && bus.imem_arb_l_lock) begin
        win_l = bus.imem_arb_l_req;
      end else if (bus.imem_arb_f_req && bus.imem_arb_l_req) begin
        win_f = fetch_turn;
        win_l = !fetch_turn;
      end else begin
        win_f = bus.imem_arb_f_req;
        win_l = bus.imem_arb_l_req;
      end
      e_addr  = win_f ? bus.imem_arb_f_addr : (win_l ? bus.imem_arb_l_addr : '0);
      e_wdata = win_l ? bus.imem_arb_l_wdata : '0;
      chk("gnt",    {bus.imem_arb_f_gnt, bus.imem_arb_l_gnt}, {win_f, win_l});
      chk("strobe", {bus.imem_arb_mem_rd, bus.imem_arb_mem_wr},
          {win_f | (win_l & !bus.imem_arb_l_we), win_l & bus.imem_arb_l_we});
      chk("addr",   bus.imem_arb_mem_addr, e_addr);
      chk("wdata",  bus.imem_arb_mem_wdata, e_wdata);
      chk("rvalid", {bus.imem_arb_f_rvalid, bus.imem_arb_l_rvalid}, {pend_f, pend_l});
      // ownership and turn for the next cycle
      exclusive = bus.imem_arb_l_lock && (exclusive || win_l);
      if (win_f) fetch_turn = 1'b0;
      else if (win_l) fetch_turn = 1'b1;
      pend_f    = win_f;
      pend_l    = win_l && !bus.imem_arb_l_we;
      init_left = 0;
    end
    chk("rdata", bus.imem_arb_rdata, bus.imem_arb_mem_rdata);
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
    rd_val = $urandom;
    bus.imem_arb_mem_rdata = rd_val;
  endtask

  task automatic idle_in();
    bus.imem_arb_f_req   = 1'b0;
    bus.imem_arb_f_addr  = '0;
    bus.imem_arb_l_req   = 1'b0;
    bus.imem_arb_l_we    = 1'b0;
    bus.imem_arb_l_lock  = 1'b0;
    bus.imem_arb_l_addr  = '0;
    bus.imem_arb_l_wdata = '0;
  endtask

  initial begin
    idle_in();
    bus.imem_arb_mem_rdata = '0;
    repeat (3) tick();

    // Reset release with a fetch waiting: one idle cycle, then the grant.
    rst_n = 1'b1;
    bus.imem_arb_f_req  = 1'b1;
    bus.imem_arb_f_addr = 32'h0000_0010;
    #1;
    chk("init_f_gnt", bus.imem_arb_f_gnt, 64'd0);
    chk("init_mem_rd", bus.imem_arb_mem_rd, 64'd0);
    tick(); #1;
    chk("first_f_gnt", bus.imem_arb_f_gnt, 64'd1);
    chk("first_mem_rd", bus.imem_arb_mem_rd, 64'd1);
    chk("first_mem_addr", bus.imem_arb_mem_addr, 64'h10);
    tick();
    bus.imem_arb_f_req = 1'b0;
    #1;
    chk("first_f_rvalid", bus.imem_arb_f_rvalid, 64'd1);
    chk("first_rdata", bus.imem_arb_rdata, {32'd0, rd_val});

    // Loader read so that fetch wins the following conflict.
    tick();
    bus.imem_arb_l_req  = 1'b1;
    bus.imem_arb_l_we   = 1'b0;
    bus.imem_arb_l_addr = 32'h0000_0100;
    #1;
    chk("prep_l_gnt", bus.imem_arb_l_gnt, 64'd1);

    // Both requesting for four cycles: F, L, F, L.
    for (int k = 0; k < 4; k++) begin
      tick();
      bus.imem_arb_f_req  = 1'b1;
      bus.imem_arb_l_req  = 1'b1;
      bus.imem_arb_f_addr = 32'h0000_0200 + 32'(k * 4);
      bus.imem_arb_l_addr = 32'h0000_0300 + 32'(k * 4);
      #1;
      chk("rr_f_gnt", bus.imem_arb_f_gnt, 64'(k % 2 == 0));
      chk("rr_l_gnt", bus.imem_arb_l_gnt, 64'(k % 2 == 1));
      chk("rr_f_rvalid", bus.imem_arb_f_rvalid, 64'(k % 2 == 1));
      chk("rr_l_rvalid", bus.imem_arb_l_rvalid, 64'(k % 2 == 0));
    end

    // Fetch-only cycle so the loader wins the first locked write.
    tick();
    bus.imem_arb_l_req  = 1'b0;
    bus.imem_arb_f_addr = 32'h0000_0040;
    #1;
    chk("pre_lock_f_gnt", bus.imem_arb_f_gnt, 64'd1);

    // Locked burst of three writes with fetch waiting.
    for (int k = 0; k < 3; k++) begin
      tick();
      bus.imem_arb_l_req   = 1'b1;
      bus.imem_arb_l_we    = 1'b1;
      bus.imem_arb_l_lock  = 1'b1;
      bus.imem_arb_l_addr  = 32'(k * 4);
      bus.imem_arb_l_wdata = 32'hA5A5_0000 + 32'(k);
      #1;
      chk("lock_l_gnt", bus.imem_arb_l_gnt, 64'd1);
      chk("lock_f_gnt", bus.imem_arb_f_gnt, 64'd0);
      chk("lock_mem_wr", bus.imem_arb_mem_wr, 64'd1);
      chk("lock_addr", bus.imem_arb_mem_addr, 64'(k * 4));
      chk("lock_l_rvalid", bus.imem_arb_l_rvalid, 64'd0);
    end
    tick();
    bus.imem_arb_l_lock = 1'b0;
    bus.imem_arb_l_req  = 1'b0;
    bus.imem_arb_l_we   = 1'b0;
    #1;
    chk("unlock_f_gnt", bus.imem_arb_f_gnt, 64'd1);
    chk("unlock_l_rvalid", bus.imem_arb_l_rvalid, 64'd0);
    tick(); #1;
    chk("post_unlock_f_gnt", bus.imem_arb_f_gnt, 64'd1);

    // Lock without a loader request changes nothing.
    for (int k = 0; k < 3; k++) begin
      tick();
      bus.imem_arb_l_lock = 1'b1;
      bus.imem_arb_f_addr = 32'h0000_0800 + 32'(k * 4);
      #1;
      chk("idle_lock_f_gnt", bus.imem_arb_f_gnt, 64'd1);
    end

    // Reset in the middle of a granted fetch.
    tick();
    bus.imem_arb_l_lock = 1'b0;
    #1;
    chk("pre_rst_f_gnt", bus.imem_arb_f_gnt, 64'd1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("rst_now_f_gnt", bus.imem_arb_f_gnt, 64'd0);
    chk("rst_now_mem_rd", bus.imem_arb_mem_rd, 64'd0);
    tick(); #1;
    chk("rst_f_rvalid", bus.imem_arb_f_rvalid, 64'd0);
    tick();
    rst_n = 1'b1;
    #1;
    chk("rst_init_f_gnt", bus.imem_arb_f_gnt, 64'd0);
    tick(); #1;
    chk("rst_first_f_gnt", bus.imem_arb_f_gnt, 64'd1);

    // Randomized traffic with occasional resets.
    for (int c = 0; c < 3000; c++) begin
      tick();
      rst_n                = ($urandom_range(0, 199) != 0);
      bus.imem_arb_f_req   = ($urandom_range(0, 3) != 0);
      bus.imem_arb_f_addr  = $urandom;
      bus.imem_arb_l_req   = ($urandom_range(0, 2) != 0);
      bus.imem_arb_l_we    = $urandom_range(0, 1);
      bus.imem_arb_l_lock  = ($urandom_range(0, 2) != 0);
      bus.imem_arb_l_addr  = $urandom;
      bus.imem_arb_l_wdata = $urandom;
    end
    tick();
    rst_n = 1'b1;
    idle_in();
    repeat (2) tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/imem_arb.md
IMEM_ARB -- requirements
Module: imem_arb

Interface
REQ-001 Parameter AW, default 32, address width in bits.
REQ-002 Parameter DW, default 32, data width in bits.
REQ-003 imem_arb_clk  in  1  single clock; all state updates on rising edge.
REQ-004 imem_arb_reset_in  in  1  reset, asynchronous, active-low.
REQ-005 imem_arb_f_req  in  1  core fetch read request, level, held until granted.
REQ-006 imem_arb_f_addr  in  AW  fetch address.
REQ-007 imem_arb_f_gnt  out  1  fetch granted this cycle.
REQ-008 imem_arb_f_rvalid  out  1  fetch read data valid on imem_arb_rdata.
REQ-009 imem_arb_l_req  in  1  program-loader request, level, held until granted.
REQ-010 imem_arb_l_we  in  1  loader access is a write (1) or a read (0).
REQ-011 imem_arb_l_lock  in  1  loader requests exclusive ownership of memory.
REQ-012 imem_arb_l_addr  in  AW  loader address.
REQ-013 imem_arb_l_wdata  in  DW  loader write data.
REQ-014 imem_arb_l_gnt  out  1  loader granted this cycle.
REQ-015 imem_arb_l_rvalid  out  1  loader read data valid on imem_arb_rdata.
REQ-016 imem_arb_rdata  out  DW  shared read data, direct pass-through of imem_arb_mem_rdata.
REQ-017 imem_arb_mem_addr / mem_wdata  out  AW / DW  memory address and write data from the granted requester; 0 when idle.
REQ-018 imem_arb_mem_rd / mem_wr  out  1 / 1  memory read / write strobes, one-hot or both 0.
REQ-019 imem_arb_mem_rdata  in  DW  memory read data, valid exactly one cycle after mem_rd.

Function
REQ-020 FSM states SHALL be INIT, RUN, LOCK.
REQ-021 INIT: no grants, no strobes; exit unconditionally to RUN after exactly one cycle (memory read held off for first cycle after reset release).
REQ-022 RUN: at most one grant per cycle; grant, mem strobes, mem_addr, mem_wdata combinational from current-cycle requests and state.
REQ-023 RUN, only f_req: f_gnt=1, mem_rd=1, mem_addr=f_addr.
REQ-024 RUN, only l_req: l_gnt=1, mem_wr=l_we, mem_rd=!l_we, mem_addr=l_addr, mem_wdata=l_wdata.
REQ-025 RUN, both requests: round-robin; requester not served in the last granted cycle wins; pointer updates only on cycles with a grant.
REQ-026 RUN to LOCK when l_gnt=1 and l_lock=1 in the same cycle.
REQ-027 LOCK: f_gnt=0 regardless of f_req; l_req granted every cycle it is asserted; stay while l_lock=1; to RUN on first cycle l_lock=0 (that cycle arbitrates as RUN but returns to RUN state, and next-cycle winner is fetch if f_req).
REQ-028 f_rvalid SHALL be 1 exactly in the cycle after a cycle with f_gnt=1.
REQ-029 l_rvalid SHALL be 1 exactly in the cycle after a cycle with l_gnt=1 and l_we=0; writes produce no rvalid.
REQ-030 f_rvalid and l_rvalid SHALL never be 1 in the same cycle.
REQ-031 Back-to-back grants SHALL be sustained: one access per cycle, no bubble, in RUN and LOCK.
REQ-032 Address and data SHALL pass unmodified; no width conversion or arithmetic.
REQ-033 l_lock without l_req SHALL have no effect.

Reset
REQ-034 On imem_arb_reset_in=0, immediately: state=INIT, f_rvalid=0, l_rvalid=0, round-robin pointer = loader-last (fetch wins first conflict), f_gnt=l_gnt=mem_rd=mem_wr=0.
REQ-035 Reset mid-operation SHALL drop any pending rvalid and release LOCK; no response for the interrupted access.
REQ-036 Reset deassertion SHALL be followed by exactly one INIT cycle before the first grant.

Verification
REQ-037 Reset release with f_req=1, f_addr=0x00000010 -> cycle 0 no strobe; cycle 1 f_gnt=1, mem_rd=1, mem_addr=0x10; cycle 2 f_rvalid=1, rdata=mem_rdata.
REQ-038 f_req and l_req (read) both held for 4 cycles from RUN -> grants alternate F,L,F,L; rvalid alternates one cycle later, never both.
REQ-039 l_req=1, l_we=1, l_lock=1, addr 0x0,0x4,0x8 over 3 cycles with f_req=1 -> 3 consecutive mem_wr, f_gnt=0 throughout, no l_rvalid; l_lock=0 next cycle, then f_gnt=1 the cycle after.
REQ-040 Reset asserted in cycle with f_gnt=1 -> next cycle f_rvalid=0, all outputs 0, one INIT cycle after release.
REQ-041 l_lock=1 with l_req=0 in RUN and f_req=1 -> f_gnt=1 every cycle, state remains RUN.
